// File: rtl/rm_serial_decoder.sv
// Serial 16-bit codeword receiver: shifts in data byte plus interleaved E/O parity,
// classifies the word as clean, parity-corrected or uncorrectable, and holds it until taken.
`timescale 1ns/1ps
module rm_serial_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       error_detected,
  output logic       error_corrected,
  output logic       frame_timeout,
  output logic [7:0] err_count
);

  localparam int unsigned CwW   = 16;
  localparam int unsigned CntW  = 4;
  localparam int unsigned IdleW = 16;

  typedef enum logic [1:0] {RECV, DECODE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [CwW-1:0]    cw_q, cw_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              err_det_q, err_det_d;
  logic              err_cor_q, err_cor_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              bit_ready_q, bit_ready_d;

  logic              par_e, par_o, bit_hs;
  logic [7:0]        syndrome;

  // Even-indexed parity bits carry E, odd-indexed carry O.
  assign par_e    = cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6];
  assign par_o    = cw_q[1] ^ cw_q[3] ^ cw_q[5] ^ cw_q[7];
  assign syndrome = {par_o, par_e, par_o, par_e, par_o, par_e, par_o, par_e} ^ cw_q[15:8];
  assign bit_hs   = bit_valid && bit_ready_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    idle_d       = idle_q;
    cw_d         = cw_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    err_det_d    = err_det_q;
    err_cor_d    = err_cor_q;
    timeout_d    = 1'b0;
    err_count_d  = err_count_q;

    unique case (state_q)
      RECV: begin
        if (bit_hs) begin
          cw_d[bit_cnt_q] = bit_in;
          bit_cnt_d       = bit_cnt_q + CntW'(1);
          idle_d          = '0;
          if (bit_cnt_q == CntW'(CwW - 1)) state_d = DECODE;
        end else if (bit_cnt_q != '0) begin
          // A bit arriving on the expiry cycle wins, so only idle cycles can time out.
          if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
            bit_cnt_d = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + IdleW'(1);
          end
        end else begin
          idle_d = '0;
        end
      end
      DECODE: begin
        data_out_d   = cw_q[7:0];
        data_valid_d = 1'b1;
        err_det_d    = 1'b0;
        err_cor_d    = 1'b0;
        if (syndrome == '0) begin
          err_cor_d = 1'b0;
        end else if ($onehot(syndrome)) begin
          err_cor_d = 1'b1;
        end else begin
          err_det_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (data_ready) begin
          data_valid_d = 1'b0;
          err_det_d    = 1'b0;
          err_cor_d    = 1'b0;
          bit_cnt_d    = '0;
          idle_d       = '0;
          state_d      = RECV;
        end
      end
      default: state_d = RECV;
    endcase

    if (flush) begin
      state_d      = RECV;
      bit_cnt_d    = '0;
      idle_d       = '0;
      data_out_d   = '0;
      data_valid_d = 1'b0;
      err_det_d    = 1'b0;
      err_cor_d    = 1'b0;
      timeout_d    = 1'b0;
    end

    bit_ready_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RECV;
      bit_cnt_q    <= '0;
      idle_q       <= '0;
      cw_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      err_det_q    <= 1'b0;
      err_cor_q    <= 1'b0;
      timeout_q    <= 1'b0;
      err_count_q  <= '0;
      bit_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_q       <= idle_d;
      cw_q         <= cw_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      err_det_q    <= err_det_d;
      err_cor_q    <= err_cor_d;
      timeout_q    <= timeout_d;
      err_count_q  <= err_count_d;
      bit_ready_q  <= bit_ready_d;
    end
  end

  assign bit_ready       = bit_ready_q;
  assign data_out        = data_out_q;
  assign data_valid      = data_valid_q;
  assign error_detected  = err_det_q;
  assign error_corrected = err_cor_q;
  assign frame_timeout   = timeout_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_rm_serial_decoder.sv
// Bench for rm_serial_decoder: directed corner frames plus random codewords
// checked against a parity/syndrome reference model.
`timescale 1ns/1ps
module tb_rm_serial_decoder;

  localparam int unsigned TO = 64;

  logic       clk = 1'b0;
  logic       rst_n, flush, bit_in, bit_valid, data_ready;
  logic       bit_ready, data_valid, error_detected, error_corrected, frame_timeout;
  logic [7:0] data_out, err_count;

  int checks = 0;
  int errors = 0;
  int m_err_count = 0;

  rm_serial_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .error_detected(error_detected),
    .error_corrected(error_corrected), .frame_timeout(frame_timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parity byte from the code rule: even positions carry E, odd carry O.
  function automatic logic [7:0] exp_parity(input logic [7:0] d);
    int e = 0;
    int o = 0;
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) e = e ^ int'(d[i]);
      else            o = o ^ int'(d[i]);
    end
    for (int i = 0; i < 8; i++) p[i] = (i % 2 == 0) ? e[0] : o[0];
    return p;
  endfunction

  task automatic send_bits(input logic [15:0] cw, input int lo, input int hi, input int gap_max);
    for (int i = lo; i <= hi; i++) begin
      int gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      bit_valid = 1'b0;
      repeat (gap) @(negedge clk);
      check("bit_ready_recv", bit_ready, 1);
      bit_valid = 1'b1;
      bit_in    = cw[i];
      @(negedge clk);
    end
    bit_valid = 1'b0;
  endtask

  // Called right after the bit-15 handshake edge; checks decode, hold and release/flush.
  task automatic finish_frame(input logic [15:0] cw, input int hold, input bit use_flush);
    logic [7:0] s;
    logic exp_det, exp_cor;
    s = exp_parity(cw[7:0]) ^ cw[15:8];
    exp_det = 1'b0;
    exp_cor = 1'b0;
    if (s != 8'h00) begin
      if ($countones(s) == 1) exp_cor = 1'b1;
      else begin
        exp_det = 1'b1;
        if (m_err_count < 255) m_err_count++;
      end
    end
    check("dv_in_decode", data_valid, 0);
    check("bit_ready_decode", bit_ready, 0);
    @(negedge clk);
    check("dv_rise", data_valid, 1);
    check("data_out", data_out, cw[7:0]);
    check("err_det", error_detected, exp_det);
    check("err_cor", error_corrected, exp_cor);
    check("err_count", err_count, m_err_count);
    check("bit_ready_hold", bit_ready, 0);
    for (int h = 0; h < hold; h++) begin
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      @(negedge clk);
      check("dv_held", data_valid, 1);
      check("data_held", data_out, cw[7:0]);
      check("flags_held", {error_detected, error_corrected}, {exp_det, exp_cor});
      check("bit_ready_held", bit_ready, 0);
    end
    bit_valid = 1'b0;
    data_ready = 1'b1;
    if (use_flush) flush = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    flush = 1'b0;
    check("dv_clear", data_valid, 0);
    check("flags_clear", {error_detected, error_corrected}, 2'b00);
    check("bit_ready_back", bit_ready, 1);
    check("err_count_after", err_count, m_err_count);
    if (use_flush) begin
      check("flush_data_out", data_out, 0);
      check("flush_timeout", frame_timeout, 0);
    end
  endtask

  task automatic send_frame(input logic [15:0] cw, input int gap_max, input int hold);
    send_bits(cw, 0, 15, gap_max);
    finish_frame(cw, hold, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_dv"}, data_valid, 0);
    check({tag, "_flags"}, {error_detected, error_corrected, frame_timeout}, 3'b000);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    int pulses;
    int at_k;
    logic [15:0] cw;
    logic [7:0]  d;
    rst_n = 1'b0; flush = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; data_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("bit_ready_after_rst", bit_ready, 1);

    send_frame(16'h5501, 0, 0);
    send_frame(16'h5701, 0, 0);
    send_frame(16'h00A4, 0, 0);
    check("err_count_one", err_count, 1);
    send_frame(16'hFF03, 0, 10);

    // Partial frame abandoned after exactly TO idle cycles.
    send_bits(16'h5501, 0, 4, 0);
    pulses = 0; at_k = 0;
    for (int k = 1; k <= int'(TO) + 6; k++) begin
      @(negedge clk);
      if (frame_timeout) begin
        pulses++;
        if (pulses == 1) at_k = k;
      end
    end
    check("to_pulses", pulses, 1);
    check("to_cycle", at_k, TO);
    check("to_err_count", err_count, m_err_count);
    send_frame(16'h5501, 0, 0);

    // A bit landing on the expiry cycle is accepted instead of timing out.
    cw = {exp_parity(8'h3C), 8'h3C};
    send_bits(cw, 0, 4, 0);
    pulses = 0;
    for (int k = 1; k < int'(TO); k++) begin
      @(negedge clk);
      if (frame_timeout) pulses++;
    end
    send_bits(cw, 5, 5, 0);
    check("edge_no_to", pulses + int'(frame_timeout), 0);
    send_bits(cw, 6, 15, 0);
    finish_frame(cw, 0, 1'b0);

    // Reset mid-frame, then flush while holding a word.
    send_bits(16'h00A4, 0, 7, 0);
    rst_n = 1'b0;
    m_err_count = 0;
    @(negedge clk);
    check_reset_values("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("bit_ready_midrst", bit_ready, 1);
    send_bits(16'h5501, 0, 15, 0);
    finish_frame(16'h5501, 2, 1'b1);
    check_reset_values("flush");
    send_frame(16'hFF03, 1, 0);

    // Random codewords: clean, parity-bit flip, data-bit flip, arbitrary.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_bits(16'($urandom), 0, $urandom_range(0, 14), 1);
        flush = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bit_valid = 1'b0;
        check("mid_flush_ready", bit_ready, 1);
        check("mid_flush_dv", data_valid, 0);
      end
      d  = 8'($urandom);
      cw = {exp_parity(d), d};
      case ($urandom_range(0, 3))
        1: cw[8 + $urandom_range(0, 7)] ^= 1'b1;
        2: cw[$urandom_range(0, 7)] ^= 1'b1;
        3: cw = 16'($urandom);
        default: ;
      endcase
      send_frame(cw, 2, $urandom_range(0, 3));
    end
    check("final_err_count", err_count, m_err_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
